// File: rtl/bt_cmd_decoder_pkg.sv
// bt_cmd_decoder_pkg: shared state encodings, defaults and command codes for the BT command decoder
package bt_cmd_decoder_pkg;
  typedef enum logic [1:0] {
    DEC_IDLE     = 2'b00,
    DEC_WAIT_CMD = 2'b01,
    DEC_WAIT_ARG = 2'b10,
    DEC_WAIT_CHK = 2'b11
  } dec_state_e;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam logic [15:0] TIMEOUT_TICKS_DEF = 16'd2000;
  localparam logic [7:0] CMD_LEFT = 8'h01;
  localparam logic [7:0] CMD_RIGHT = 8'h02;
  localparam logic [7:0] CMD_FIRE = 8'h03;
  function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] a);
    return c ^ a;
  endfunction
endpackage

// File: rtl/bt_cmd_decoder_if.sv
// bt_cmd_decoder_if: byte-in / command-out bundle between UART receiver, decoder and game logic
interface bt_cmd_decoder_if;
  logic avail;
  logic [7:0] din;
  logic cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic frame_err;
  logic [7:0] err_count;
  logic busy;
  modport master (output avail, din, input cmd_valid, cmd, arg, frame_err, err_count, busy);
  modport slave (input avail, din, output cmd_valid, cmd, arg, frame_err, err_count, busy);
endinterface

// File: rtl/bt_timeout_counter.sv
// bt_timeout_counter: idle-tick counter that strobes expire when it reaches limit-1 and restarts
module bt_timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    expire = enable && !clear && (cnt_q == limit - 1'b1);
    cnt_d = (clear || expire) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/bt_cmd_decoder.sv
// bt_cmd_decoder: assembles SYNC/CMD/ARG/CHK frames from the UART byte stream and
// emits validated (cmd, arg) pairs, flagging checksum errors and inter-byte stalls
module bt_cmd_decoder
  import bt_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input logic clk_div,
  input logic rst_n,
  bt_cmd_decoder_if.slave bus
);
  dec_state_e state_q, state_d;
  logic [7:0] cmd_s_q, cmd_s_d, arg_s_q, arg_s_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, err_count_q, err_count_d;
  logic cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
  logic idle, expire;
  assign idle = state_q == DEC_IDLE;
  bt_timeout_counter #(.W(16)) u_timeout (
    .clk    (clk_div),
    .rst_n  (rst_n),
    .clear  (bus.avail || idle),
    .enable (!idle),
    .limit  (TIMEOUT_TICKS),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    cmd_s_d = cmd_s_q;
    arg_s_d = arg_s_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (bus.avail) begin
      case (state_q)
        DEC_IDLE: state_d = (bus.din == SYNC_BYTE) ? DEC_WAIT_CMD : DEC_IDLE;
        DEC_WAIT_CMD: begin
          cmd_s_d = bus.din;
          state_d = DEC_WAIT_ARG;
        end
        DEC_WAIT_ARG: begin
          arg_s_d = bus.din;
          state_d = DEC_WAIT_CHK;
        end
        default: begin
          cmd_valid_d = bus.din == frame_chk(cmd_s_q, arg_s_q);
          frame_err_d = !cmd_valid_d;
          cmd_d = cmd_valid_d ? cmd_s_q : cmd_q;
          arg_d = cmd_valid_d ? arg_s_q : arg_q;
          state_d = DEC_IDLE;
        end
      endcase
    end else if (expire) begin
      frame_err_d = 1'b1;
      state_d = DEC_IDLE;
    end
    err_count_d = (frame_err_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  end
  always_ff @(posedge clk_div or negedge rst_n)
    if (!rst_n) begin
      state_q <= DEC_IDLE;
      cmd_s_q <= '0;
      arg_s_q <= '0;
      cmd_q <= '0;
      arg_q <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_s_q <= cmd_s_d;
      arg_s_q <= arg_s_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd = cmd_q;
  assign bus.arg = arg_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_count = err_count_q;
  assign bus.busy = !idle;
endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb_bt_cmd_decoder: directed test-plan frames plus randomized frame streams against a
// frame-level reference model of the decoder
module tb_bt_cmd_decoder;
  localparam int T = 2000;
  localparam logic [7:0] SYNC = 8'hAA;
  logic clk_div = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  bt_cmd_decoder_if bus ();
  bt_cmd_decoder #(.SYNC_BYTE(SYNC), .TIMEOUT_TICKS(16'(T))) dut (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .bus     (bus)
  );
  always #5 clk_div = ~clk_div;
  int pos, gap, m_cnt;
  logic [7:0] c_s, a_s, m_cmd, m_arg;
  logic m_valid, m_err;
  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_reset();
    pos = 0; gap = 0; m_cnt = 0;
    c_s = 0; a_s = 0; m_cmd = 0; m_arg = 0;
    m_valid = 0; m_err = 0;
  endfunction
  function automatic void model(input logic av, input logic [7:0] d);
    m_valid = 0;
    m_err = 0;
    if (av) begin
      gap = 0;
      if (pos == 0) pos = (d == SYNC) ? 1 : 0;
      else if (pos == 1) begin c_s = d; pos = 2; end
      else if (pos == 2) begin a_s = d; pos = 3; end
      else begin
        if (d == (c_s ^ a_s)) begin m_valid = 1; m_cmd = c_s; m_arg = a_s; end
        else m_err = 1;
        pos = 0;
      end
    end else if (pos != 0) begin
      if (gap == T - 1) begin m_err = 1; pos = 0; gap = 0; end
      else gap++;
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endfunction
  task automatic compare_all();
    chk("cmd_valid", bus.cmd_valid, m_valid);
    chk("frame_err", bus.frame_err, m_err);
    chk("cmd", bus.cmd, m_cmd);
    chk("arg", bus.arg, m_arg);
    chk("err_count", bus.err_count, m_cnt);
    chk("busy", bus.busy, pos != 0);
  endtask
  task automatic step(input logic av, input logic [7:0] d);
    @(negedge clk_div);
    bus.avail = av;
    bus.din = d;
    @(posedge clk_div);
    model(av, d);
    #1 compare_all();
  endtask
  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask
  task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send(SYNC); send(c); send(a); send(k);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, bus.cmd_valid, 0);
    chk({tag, "_err"}, bus.frame_err, 0);
    chk({tag, "_cmd"}, bus.cmd, 0);
    chk({tag, "_arg"}, bus.arg, 0);
    chk({tag, "_cnt"}, bus.err_count, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask
  initial begin
    bus.avail = 1'b0;
    bus.din = 8'h00;
    model_reset();
    #1 check_zero("rst");
    repeat (3) @(posedge clk_div);
    @(negedge clk_div) rst_n = 1'b1;
    frame(8'h01, 8'h05, 8'h04);
    chk("tp_valid", bus.cmd_valid, 1);
    chk("tp_cmd", bus.cmd, 8'h01);
    chk("tp_arg", bus.arg, 8'h05);
    frame(8'h02, 8'h03, 8'h00);
    chk("tp_bad_err", bus.frame_err, 1);
    chk("tp_bad_cnt", bus.err_count, 1);
    chk("tp_bad_cmd", bus.cmd, 8'h01);
    send(8'h13); send(8'h55);
    frame(8'h03, 8'h00, 8'h03);
    chk("tp_garbage_cmd", bus.cmd, 8'h03);
    send(SYNC); send(8'h01);
    idle(T);
    chk("tp_timeout_err", bus.frame_err, 1);
    chk("tp_timeout_busy", bus.busy, 0);
    frame(8'h01, 8'h01, 8'h00);
    chk("tp_after_to", bus.cmd_valid, 1);
    for (int i = 0; i < 260; i++) frame(8'h02, 8'h03, 8'h00);
    chk("tp_sat", bus.err_count, 8'hFF);
    send(SYNC); send(8'h02);
    idle(T - 1);
    send(8'h05);
    chk("tp_simul_err", bus.frame_err, 0);
    chk("tp_simul_busy", bus.busy, 1);
    send(8'h07);
    chk("tp_simul_valid", bus.cmd_valid, 1);
    send(SYNC); send(8'h07);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_zero("async_rst");
    repeat (2) @(posedge clk_div);
    @(negedge clk_div) rst_n = 1'b1;
    send(8'h07); send(8'h00); send(8'h07);
    chk("tp_no_resync", bus.cmd_valid, 0);
    for (int f = 0; f < 400; f++) begin
      logic [7:0] c, a, k;
      logic [7:0] bytes [4];
      c = 8'($urandom);
      a = 8'($urandom);
      k = ($urandom_range(0, 3) != 0) ? (c ^ a) : (c ^ a ^ 8'($urandom_range(1, 255)));
      bytes[0] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : SYNC;
      bytes[1] = c; bytes[2] = a; bytes[3] = k;
      for (int b = 0; b < 4; b++) begin
        idle(($urandom_range(0, 199) == 0) ? int'($urandom_range(T - 5, T + 5)) : int'($urandom_range(0, 2)));
        send(bytes[b]);
      end
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
